// File: rtl/uart_config_rx_pkg.sv
// Shared parser states, config word layout and checksum helpers for uart_config_rx.
// Build option: UART_CFG_RANGE_CHECK_EN enables field range rejection in the top.
package uart_config_rx_pkg;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        CHK
    } psm_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rsm_t;

    localparam int POS_MSB  = 31;
    localparam int PCT_MSB  = 23;
    localparam int SPDH_MSB = 15;
    localparam int SPDL_MSB = 7;

    localparam logic [7:0] PCT_MAX = 8'd100;

    function automatic logic [7:0] cfg_sum(input logic [31:0] w);
        return w[POS_MSB -: 8] ^ w[PCT_MSB -: 8] ^
               w[SPDH_MSB -: 8] ^ w[SPDL_MSB -: 8];
    endfunction

    function automatic logic cfg_in_range(input logic [31:0] w);
        return (w[PCT_MSB -: 8] <= PCT_MAX) &&
               (w[POS_MSB -: 8] <= 8'd1);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, start recheck at half bit,
// mid-bit sampling, one-cycle strobe or frame error after the stop sample.
module uart_rx_byte #(
    parameter int CLK_DIV = 87
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       uRx,
    output logic [7:0] byteData,
    output logic       byteStb,
    output logic       frameErr
);
    import uart_config_rx_pkg::*;

    localparam logic [11:0] HALF = 12'(CLK_DIV / 2 - 1);
    localparam logic [11:0] FULL = 12'(CLK_DIV - 1);

    logic        s1, s2, sp;
    rsm_t        st, stN;
    logic [11:0] cnt, cntN;
    logic [2:0]  bitI, bitIN;
    logic [7:0]  shf, shfN;
    logic        stbN, errN;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            sp <= 1'b1;
        end else begin
            s1 <= uRx;
            s2 <= s1;
            sp <= s2;
        end
    end

    always_comb begin
        stN   = st;
        cntN  = cnt + 12'd1;
        bitIN = bitI;
        shfN  = shf;
        stbN  = 1'b0;
        errN  = 1'b0;
        unique case (st)
            RX_IDLE: begin
                cntN = '0;
                if (sp && !s2) stN = RX_START;
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cntN  = '0;
                    bitIN = '0;
                    stN   = s2 ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (cnt == FULL) begin
                    cntN  = '0;
                    shfN  = {s2, shf[7:1]};
                    bitIN = bitI + 3'd1;
                    if (bitI == 3'd7) stN = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    cntN = '0;
                    stN  = RX_IDLE;
                    stbN = s2;
                    errN = !s2;
                end
            end
            default: stN = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            st       <= RX_IDLE;
            cnt      <= '0;
            bitI     <= '0;
            shf      <= '0;
            byteStb  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            st       <= stN;
            cnt      <= cntN;
            bitI     <= bitIN;
            shf      <= shfN;
            byteStb  <= stbN;
            frameErr <= errN;
        end
    end

    assign byteData = shf;

endmodule

// File: rtl/uart_config_rx.sv
// UART config frame receiver: HEADER, 4 data bytes MSB first, XOR checksum.
// Build option: define UART_CFG_RANGE_CHECK_EN to reject out-of-range fields.
module uart_config_rx #(
    parameter int         CLK_DIV     = 87,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        uRx,
    input  logic [31:0] busDefault,
    output logic [31:0] busNow,
    output logic        cfgValid,
    output logic        cfgErr
);
    import uart_config_rx_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

    logic [7:0]    byteData;
    logic          byteStb, frameErr;
    psm_t          ps, psN;
    logic [1:0]    idx, idxN;
    logic [31:0]   shadow, shN, active, actN;
    logic          loaded, ldN;
    logic [TW-1:0] tmo, tmoN;
    logic          vN, eN, okRange;

    uart_rx_byte #(
        .CLK_DIV(CLK_DIV)
    ) u_rx (
        .clk     (clk),
        .nRst    (nRst),
        .uRx     (uRx),
        .byteData(byteData),
        .byteStb (byteStb),
        .frameErr(frameErr)
    );

`ifdef UART_CFG_RANGE_CHECK_EN
    assign okRange = cfg_in_range(shadow);
`else
    assign okRange = 1'b1;
`endif

    always_comb begin
        psN  = ps;
        idxN = idx;
        shN  = shadow;
        actN = active;
        ldN  = loaded;
        vN   = 1'b0;
        eN   = 1'b0;
        tmoN = (ps == HUNT) ? '0 : tmo + TW'(1);
        if (frameErr) begin
            psN  = HUNT;
            shN  = '0;
            tmoN = '0;
            eN   = 1'b1;
        end else if (byteStb) begin
            // a byte arriving on the expiry cycle takes priority
            tmoN = '0;
            unique case (ps)
                HUNT: begin
                    if (byteData == HEADER) begin
                        psN  = DATA;
                        idxN = '0;
                    end
                end
                DATA: begin
                    shN  = {shadow[23:0], byteData};
                    idxN = idx + 2'd1;
                    if (idx == 2'd3) psN = CHK;
                end
                CHK: begin
                    psN = HUNT;
                    if (byteData == cfg_sum(shadow) && okRange) begin
                        actN = shadow;
                        ldN  = 1'b1;
                        vN   = 1'b1;
                    end else begin
                        eN = 1'b1;
                    end
                end
                default: psN = HUNT;
            endcase
        end else if (ps != HUNT && tmo == TLIM) begin
            psN  = HUNT;
            shN  = '0;
            tmoN = '0;
            eN   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ps       <= HUNT;
            idx      <= '0;
            shadow   <= '0;
            active   <= '0;
            loaded   <= 1'b0;
            tmo      <= '0;
            cfgValid <= 1'b0;
            cfgErr   <= 1'b0;
        end else begin
            ps       <= psN;
            idx      <= idxN;
            shadow   <= shN;
            active   <= actN;
            loaded   <= ldN;
            tmo      <= tmoN;
            cfgValid <= vN;
            cfgErr   <= eN;
        end
    end

    assign busNow = loaded ? active : busDefault;

endmodule

// File: tb/tb_uart_config_rx.sv
// Randomized frame bench for uart_config_rx with a frame-level reference model.
// Works with or without UART_CFG_RANGE_CHECK_EN defined.
module tb_uart_config_rx;

    localparam int         CLK_DIV = 16;
    localparam logic [7:0] HDR     = 8'hA5;
    localparam int         TMO     = 1000;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        uRx = 1'b1;
    logic [31:0] busDefault = 32'h010A0001;
    logic [31:0] busNow;
    logic        cfgValid, cfgErr;

    int     nchk = 0;
    int     nerr = 0;
    int     nval = 0;
    int     nerrp = 0;
    int     nboth = 0;
    longint cyc = 0;
    longint lastErrCyc = 0;
    longint tEnd = 0;

    logic        mLoaded = 1'b0;
    logic [31:0] mActive = '0;
    int          expVal = 0;
    int          expErr = 0;

    always #50 clk = ~clk;

    uart_config_rx #(
        .CLK_DIV    (CLK_DIV),
        .HEADER     (HDR),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .uRx       (uRx),
        .busDefault(busDefault),
        .busNow    (busNow),
        .cfgValid  (cfgValid),
        .cfgErr    (cfgErr)
    );

    always @(negedge clk) begin
        cyc++;
        if (cfgValid) nval++;
        if (cfgErr) begin
            nerrp++;
            lastErrCyc = cyc;
        end
        if (cfgValid && cfgErr) nboth++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_bus();
        return mLoaded ? mActive : busDefault;
    endfunction

    function automatic logic frame_ok(input logic [31:0] w, input logic [7:0] c);
        logic ok;
        ok = (c == (w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]));
`ifdef UART_CFG_RANGE_CHECK_EN
        if (w[23:16] > 8'd100 || w[31:24] > 8'd1) ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uRx = 1'b0;
        idle(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            uRx = b[i];
            idle(CLK_DIV);
        end
        uRx = stop;
        idle(CLK_DIV);
        uRx = 1'b1;
        tEnd = cyc;
        idle($urandom_range(1, 20));
    endtask

    task automatic send_frame(input string tag, input logic [31:0] w,
                              input logic [7:0] c);
        send_byte(HDR, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
        send_byte(c, 1'b1);
        if (frame_ok(w, c)) begin
            mLoaded = 1'b1;
            mActive = w;
            expVal++;
        end else begin
            expErr++;
        end
        idle(10);
        check({tag, "_val"}, nval, expVal);
        check({tag, "_err"}, nerrp, expErr);
        check({tag, "_bus"}, busNow, model_bus());
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  c, g;
        longint      d;

        idle(5);
        check("rst_bus", busNow, 32'h010A0001);
        check("rst_val", cfgValid, 1'b0);
        check("rst_err", cfgErr, 1'b0);
        nRst = 1'b1;
        idle(10);
        busDefault = 32'h12345678;
        #1;
        check("dflt_follow", busNow, 32'h12345678);
        busDefault = 32'h010A0001;
        idle(5);

        send_frame("badsum", 32'h01320064, 8'h58);
        send_frame("good", 32'h01320064, 8'h57);
        busDefault = 32'hDEADBEEF;
        #1;
        check("dflt_ignored", busNow, 32'h01320064);

        @(negedge clk);
        uRx = 1'b0;
        idle(CLK_DIV / 2 - 2);
        uRx = 1'b1;
        idle(60);
        check("falsestart_err", nerrp, expErr);
        send_frame("after_false", 32'h00501234, 8'h00 ^ 8'h50 ^ 8'h12 ^ 8'h34);

        send_byte(HDR, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h32, 1'b1);
        d = tEnd;
        idle(TMO + 10);
        expErr++;
        check("tmo_err", nerrp, expErr);
        d = lastErrCyc - d;
        check("tmo_time", (d >= TMO - CLK_DIV && d <= TMO + 4), 1'b1);
        send_frame("after_tmo", 32'h0003AAAA, 8'h00 ^ 8'h03 ^ 8'hAA ^ 8'hAA);

        send_frame("range", 32'h00650010, 8'h75);

        send_byte(HDR, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        @(negedge clk);
        uRx = 1'b0;
        idle(CLK_DIV * 3);
        nRst = 1'b0;
        uRx = 1'b1;
        mLoaded = 1'b0;
        idle(3);
        check("midrst_bus", busNow, busDefault);
        check("midrst_val", cfgValid, 1'b0);
        nRst = 1'b1;
        idle(200);
        send_frame("post_rst", 32'h001401F4, 8'hE1);
        check("post_rst_exact", busNow, 32'h001401F4);

        for (int k = 0; k < 10; k++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                g = 8'($urandom);
                if (g == HDR) g = g ^ 8'h01;
                if ($urandom_range(0, 3) == 0) begin
                    send_byte(g, 1'b0);
                    expErr++;
                end else begin
                    send_byte(g, 1'b1);
                end
            end
            w[31:24] = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                  : 8'($urandom_range(0, 1));
            w[23:16] = 8'($urandom_range(0, 130));
            w[15:0]  = 16'($urandom);
            c = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_frame("rand", w, c);
            idle($urandom_range(0, 40));
        end

        check("never_both", nboth, 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/uart_config_rx.md
UART_CONFIG_RX -- requirements
Module: uart_config_rx

Interface
REQ-001 Parameter CLK_DIV, default 87, clk cycles per UART bit (10 MHz / 115200); legal range 8..4095.
REQ-002 Parameter HEADER, default 8'hA5, frame start byte.
REQ-003 Parameter TIMEOUT_CYC, default 100000, maximum idle clk cycles between bytes inside one frame.
REQ-004 Port clk, input, 1, single clock for the whole block (10 MHz domain).
REQ-005 Port nRst, input, 1, reset, asynchronous, active-low.
REQ-006 Port uRx, input, 1, asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 Port busDefault, input, 32, configuration used until the first accepted frame; fields {pos1_neg0, perCent, speedH8, speedL8}.
REQ-008 Port busNow, output, 32, active configuration, same field order as busDefault.
REQ-009 Port cfgValid, output, 1, one-cycle pulse when a frame is accepted.
REQ-010 Port cfgErr, output, 1, one-cycle pulse on checksum failure, framing error, timeout or range reject.

Function
REQ-011 uRx SHALL pass through a 2-FF synchronizer; both flops reset to 1.
REQ-012 Bit receiver SHALL detect start on a synchronized 1->0 transition, recheck low at CLK_DIV/2; if high -> false start, return to idle, no byte and no cfgErr.
REQ-013 Data bits SHALL be sampled every CLK_DIV cycles after the start midpoint, LSB first; the stop bit is sampled one CLK_DIV after bit 7.
REQ-014 Stop bit = 1 -> one-cycle byte strobe with the 8-bit value on the next clk; stop bit = 0 -> byte dropped, cfgErr pulse, parser returns to HUNT.
REQ-015 Parser states: HUNT, DATA (index 0..3), CHK.
REQ-016 HUNT: byte == HEADER -> DATA index 0; any other byte ignored, no cfgErr.
REQ-017 DATA: byte stored MSB-first into a 32-bit shadow register (index 0 -> bits 31:24); index 3 -> CHK; bytes equal to HEADER inside DATA are data, no resync.
REQ-018 CHK: byte == XOR of the 4 data bytes -> shadow copied to the active register, loaded flag set, cfgValid pulse; mismatch -> cfgErr pulse; both cases -> HUNT.
REQ-019 cfgValid/cfgErr and the busNow update SHALL occur exactly 2 clk after the checksum stop-bit sample cycle.
REQ-020 busNow SHALL equal busDefault while the loaded flag is 0, else the active register; busDefault changes propagate combinationally while unloaded.
REQ-021 Timeout counter SHALL run in DATA/CHK, clear on every byte strobe; reaching TIMEOUT_CYC -> cfgErr pulse, shadow discarded, HUNT.
REQ-022 A byte completing in the same cycle as timeout expiry SHALL win (timeout ignored).
REQ-023 cfgValid and cfgErr SHALL never be asserted in the same cycle.

Reset
REQ-024 nRst low SHALL asynchronously force: parser HUNT, bit receiver idle, counters 0, shadow and active registers 0, loaded flag 0, cfgValid 0, cfgErr 0; busNow therefore equals busDefault.
REQ-025 Reset mid-frame SHALL discard the partial frame; a frame in flight at release is received only from its next valid HEADER.

Configuration
REQ-026 Macro UART_CFG_RANGE_CHECK_EN defined: a checksum-correct frame with perCent (bits 23:16) > 100 or pos1_neg0 (bits 31:24) > 1 SHALL be rejected with cfgErr, busNow unchanged.
REQ-027 Macro undefined: range checking is absent; any checksum-correct frame is accepted.

Structure
REQ-028 A shared package SHALL hold the parser state enumeration, the field bit positions (POS_MSB, PCT_MSB, SPDH_MSB, SPDL_MSB) and the constant 100 as PCT_MAX.
REQ-029 Bit-level reception (synchronizer, start check, sampling, stop check) SHALL be a sub-module uart_rx_byte with outputs byteData[7:0], byteStb, frameErr.

Verification
REQ-030 Reset, busDefault=32'h010A0001, frame A5 01 32 00 64 57 -> cfgValid one pulse, busNow=32'h01320064; busDefault then changed -> busNow unchanged.
REQ-031 Frame A5 01 32 00 64 58 -> cfgErr one pulse, busNow stays 32'h010A0001.
REQ-032 uRx low pulse of CLK_DIV/2-2 cycles -> no byteStb, no cfgErr; valid frame then accepted.
REQ-033 A5 01 32, then idle TIMEOUT_CYC+10 cycles -> cfgErr at TIMEOUT_CYC; following full valid frame accepted.
REQ-034 With UART_CFG_RANGE_CHECK_EN, frame A5 00 65 00 10 75 -> cfgErr, busNow unchanged; without the macro -> busNow=32'h00650010.
REQ-035 Assert nRst during data byte 2 of a valid frame, release, send full frame A5 00 14 01 F4 E1 -> only this second frame accepted, busNow=32'h001401F4.
